// File: rtl/mpmc11_rd_data_gather_if.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_rd_data_gather_if
// Purpose  : Bundles the read-request, memory read-beat and assembled-read
//            handshake signals of the mpmc11 read-data gather block.
// Ports    : req_*      - read issued by the request sequencer (tag, beat count)
//            mem_rd_*   - read beats from the PHY/UI (no back-pressure)
//            dato_*     - assembled read toward the channel-return logic
//            overflow   - sticky dropped-beat error
//            idle       - nothing queued, assembling or presented
// Modports : master - sequencer/PHY/consumer side; slave - gather block side
// Revision : 1.0 - initial release
// ============================================================================
interface mpmc11_rd_data_gather_if #(
  parameter int WID  = 256,
  parameter int TAGW = 4
);
  logic            req_valid;
  logic [TAGW-1:0] req_tag;
  logic            req_two;
  logic            req_ready;
  logic            mem_rd_valid;
  logic [WID-1:0]  mem_rd_data;
  logic            dato_valid;
  logic            dato_ready;
  logic [WID-1:0]  dato1;
  logic [WID-1:0]  dato2;
  logic [TAGW-1:0] dato_tag;
  logic            overflow;
  logic            idle;

  modport master (
    output req_valid, req_tag, req_two, mem_rd_valid, mem_rd_data, dato_ready,
    input  req_ready, dato_valid, dato1, dato2, dato_tag, overflow, idle
  );

  modport slave (
    input  req_valid, req_tag, req_two, mem_rd_valid, mem_rd_data, dato_ready,
    output req_ready, dato_valid, dato1, dato2, dato_tag, overflow, idle
  );
endinterface
`default_nettype wire

// File: rtl/mpmc11_rd_data_gather.sv
`default_nettype none
// ============================================================================
// Module   : mpmc11_rd_data_gather
// Purpose  : Read-return path of the mpmc11 controller. Queues one {tag, two}
//            entry per issued read, gathers one or two memory beats into an
//            assembled read, and presents it on a valid/ready output register.
// Ports    : clk  - controller clock, rising edge
//            rstn - asynchronous active-low reset
//            bus  - slave modport of mpmc11_rd_data_gather_if (request queue
//                   push, memory read beats, assembled output, status)
// Revision : 1.0 - initial release
// ============================================================================
module mpmc11_rd_data_gather #(
  parameter int WID   = 256,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rstn,
  mpmc11_rd_data_gather_if.slave      bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_BEAT1 = 2'd0,
    ST_BEAT2 = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [WID-1:0]  w1_q, w1_d;
  logic [WID-1:0]  w2_q, w2_d;
  logic [TAGW-1:0] hold_tag_q, hold_tag_d;
  logic            dato_valid_q, dato_valid_d;
  logic [WID-1:0]  dato1_q, dato1_d;
  logic [WID-1:0]  dato2_q, dato2_d;
  logic [TAGW-1:0] dato_tag_q, dato_tag_d;
  logic            overflow_q, overflow_d;

  // Tag queue storage: written only on an accepted push, so no reset needed.
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic            two_mem [DEPTH];

  logic            full, empty, push, pop, out_free, done;
  logic [TAGW-1:0] head_tag;
  logic            head_two;
  logic [WID-1:0]  fin_w1, fin_w2;

  // Extra wrap bit distinguishes full (wrap bits differ) from empty.
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = bus.req_valid && !full;
  assign head_tag = tag_mem[rd_ptr_q[PW-1:0]];
  assign head_two = two_mem[rd_ptr_q[PW-1:0]];
  // Output register can take a new read if empty or draining this cycle.
  assign out_free = !dato_valid_q || bus.dato_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q[PW-1:0]] <= bus.req_tag;
      two_mem[wr_ptr_q[PW-1:0]] <= bus.req_two;
    end
  end

  always_comb begin
    state_d      = state_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    hold_tag_d   = hold_tag_q;
    dato_valid_d = dato_valid_q;
    dato1_d      = dato1_q;
    dato2_d      = dato2_q;
    dato_tag_d   = dato_tag_q;
    overflow_d   = overflow_q;
    pop          = 1'b0;
    done         = 1'b0;
    fin_w1       = '0;
    fin_w2       = '0;

    if (dato_valid_q && bus.dato_ready) begin
      dato_valid_d = 1'b0;
    end

    case (state_q)
      ST_BEAT1: begin
        if (bus.mem_rd_valid) begin
          if (empty) begin
            overflow_d = 1'b1;           // beat with no outstanding read
          end else if (head_two) begin
            w1_d    = bus.mem_rd_data;
            state_d = ST_BEAT2;
          end else begin
            done   = 1'b1;
            fin_w1 = bus.mem_rd_data;
          end
        end
      end
      ST_BEAT2: begin
        if (bus.mem_rd_valid) begin
          done   = 1'b1;
          fin_w1 = w1_q;
          fin_w2 = bus.mem_rd_data;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rd_valid) begin
          overflow_d = 1'b1;             // assembler busy holding a read
        end
        if (out_free) begin
          dato_valid_d = 1'b1;
          dato1_d      = w1_q;
          dato2_d      = w2_q;
          dato_tag_d   = hold_tag_q;
          state_d      = ST_BEAT1;
        end
      end
      default: state_d = ST_BEAT1;
    endcase

    // Completed read: retire its queue entry, then present or park it.
    if (done) begin
      pop = 1'b1;
      if (out_free) begin
        dato_valid_d = 1'b1;
        dato1_d      = fin_w1;
        dato2_d      = fin_w2;
        dato_tag_d   = head_tag;
        state_d      = ST_BEAT1;
      end else begin
        w1_d       = fin_w1;
        w2_d       = fin_w2;
        hold_tag_d = head_tag;
        state_d    = ST_WAIT;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_BEAT1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      hold_tag_q   <= '0;
      dato_valid_q <= 1'b0;
      dato1_q      <= '0;
      dato2_q      <= '0;
      dato_tag_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      hold_tag_q   <= hold_tag_d;
      dato_valid_q <= dato_valid_d;
      dato1_q      <= dato1_d;
      dato2_q      <= dato2_d;
      dato_tag_q   <= dato_tag_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.req_ready  = !full;
  assign bus.dato_valid = dato_valid_q;
  assign bus.dato1      = dato1_q;
  assign bus.dato2      = dato2_q;
  assign bus.dato_tag   = dato_tag_q;
  assign bus.overflow   = overflow_q;
  assign bus.idle       = empty && (state_q == ST_BEAT1) && !dato_valid_q;

endmodule
`default_nettype wire
